div_unit: RTL

- Multi-cycle integer divider serving the RV32M DIV/DIVU/REM/REMU ops that the decode stage issues with register write deferred.
- Sits beside the execute stage. Execute issues a start with operands, opcode and destination, stalls the pipeline while busy_o is high, and writes result_o to reg_waddr_o on ready_o.
- Radix-2 restoring algorithm, one quotient bit per cycle, with RISC-V-mandated corner-case results.

---
 rtl/div_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero results follow the RISC-V rules.
module div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [4:0]            reg_waddr_o
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] dvd_reg;
  logic [DATA_WIDTH-1:0] dvs_reg;
  logic [1:0]            op_sel_reg;   // [1]=remainder, [0]=unsigned
  logic [4:0]            waddr_reg;
  logic [DATA_WIDTH-1:0] dvs_mag_reg;
  logic [DATA_WIDTH-1:0] quot_reg;
  logic [DATA_WIDTH:0]   rem_reg;
  logic                  sign_q_reg;
  logic                  sign_r_reg;
  logic [CW-1:0]         count_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  ready_reg;
  logic                  busy_reg;
  logic [4:0]            waddr_out_reg;

  logic                  signed_op;
  logic                  dvd_neg;
  logic                  dvs_neg;
  logic [DATA_WIDTH-1:0] dvd_mag;
  logic [DATA_WIDTH-1:0] dvs_mag;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   rem_next;
  logic [DATA_WIDTH-1:0] quot_next;
  logic [DATA_WIDTH-1:0] quot_fix;
  logic [DATA_WIDTH-1:0] rem_fix;

  always_comb begin
    signed_op = ~op_sel_reg[0];
    dvd_neg   = signed_op & dvd_reg[DATA_WIDTH-1];
    dvs_neg   = signed_op & dvs_reg[DATA_WIDTH-1];
    dvd_mag   = dvd_neg ? (~dvd_reg + 1'b1) : dvd_reg;
    dvs_mag   = dvs_neg ? (~dvs_reg + 1'b1) : dvs_reg;

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    rem_shift = {rem_reg[DATA_WIDTH-1:0], quot_reg[DATA_WIDTH-1]};
    rem_next  = rem_shift;
    quot_next = {quot_reg[DATA_WIDTH-2:0], 1'b0};
    if (rem_shift >= {1'b0, dvs_mag_reg}) begin
      rem_next     = rem_shift - {1'b0, dvs_mag_reg};
      quot_next[0] = 1'b1;
    end

    quot_fix = sign_q_reg ? (~quot_reg + 1'b1) : quot_reg;
    rem_fix  = sign_r_reg ? (~rem_reg[DATA_WIDTH-1:0] + 1'b1) : rem_reg[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      op_sel_reg    <= '0;
      waddr_reg     <= '0;
      dvs_mag_reg   <= '0;
      quot_reg      <= '0;
      rem_reg       <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      count_reg     <= '0;
      result_reg    <= '0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      waddr_out_reg <= '0;
    end else begin
      ready_reg <= 1'b0;
      if (flush_i) begin
        state_reg <= S_IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start_i && op_i[2]) begin
              dvd_reg    <= dividend_i;
              dvs_reg    <= divisor_i;
              op_sel_reg <= op_i[1:0];
              waddr_reg  <= reg_waddr_i;
              state_reg  <= S_START;
              busy_reg   <= 1'b1;
            end
          end
          S_START: begin
            count_reg <= '0;
            if (dvs_reg == '0) begin
              // Quotient of all ones and remainder = raw dividend, no sign fix.
              quot_reg   <= '1;
              rem_reg    <= {1'b0, dvd_reg};
              sign_q_reg <= 1'b0;
              sign_r_reg <= 1'b0;
              state_reg  <= S_END;
            end else begin
              quot_reg    <= dvd_mag;
              rem_reg     <= '0;
              dvs_mag_reg <= dvs_mag;
              sign_q_reg  <= dvd_neg ^ dvs_neg;
              sign_r_reg  <= dvd_neg;
              state_reg   <= S_CALC;
            end
          end
          S_CALC: begin
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            count_reg <= count_reg + 1'b1;
            if (count_reg == CW'(DATA_WIDTH - 1)) begin
              state_reg <= S_END;
            end
          end
          S_END: begin
            result_reg    <= op_sel_reg[1] ? rem_fix : quot_fix;
            waddr_out_reg <= waddr_reg;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= S_IDLE;
          end
          default: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign result_o    = result_reg;
  assign ready_o     = ready_reg;
  assign busy_o      = busy_reg;
  assign reg_waddr_o = waddr_out_reg;

endmodule
